// File: rtl/fetch_cycle.sv
// Purpose : instruction fetch stage - owns pc_F, the F-D pipeline register and
//           the interrupt entry/return state machine.
// Latency : 1 edge from pc_F=A to the word at A appearing on instruction_D.
// Backpressure: add_stall holds pc_F and F-D; a taken branch or an interrupt
//           entry overrides the stall and flushes F-D with a bubble.
//
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   add_stall         - load-use stall from the hazard unit
//   isbranch_taken_E  - redirect (branch/call/ret/iret) resolved in EX
//   branch_pc_E       - redirect target from EX
//   isIret_E          - iret present in EX (leaves the interrupt handler)
//   interrupt         - level-sensitive external interrupt request
//   imem_data         - instruction word at imem_addr (combinational memory)
//   imem_addr         - current fetch PC
//   pc_D, instruction_D - F-D pipeline register contents
//   int_active        - high while the interrupt handler executes
module fetch_cycle #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] INT_VECTOR = 32'h0000_0100,
   parameter logic [31:0] NOP_INSTR  = 32'h6800_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        add_stall,
   input  logic        isbranch_taken_E,
   input  logic [31:0] branch_pc_E,
   input  logic        isIret_E,
   input  logic        interrupt,
   input  logic [31:0] imem_data,
   output logic [31:0] imem_addr,
   output logic [31:0] pc_D,
   output logic [31:0] instruction_D,
   output logic        int_active
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_PEND   = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] pc_d_q, pc_d_d;
   logic [31:0] instr_d_q, instr_d_d;

   logic        int_req;
   logic        int_entry;

   // A request is live when a fresh interrupt arrives in RUN or one was
   // latched earlier (PEND). It may only redirect fetch on an edge that
   // carries neither a branch nor a stall, so the redirect never races the
   // EX-stage redirect or a held instruction.
   always_comb begin
      int_req   = ((state_q == S_RUN) && interrupt) || (state_q == S_PEND);
      int_entry = int_req && !isbranch_taken_E && !add_stall;
   end

   // Next-PC / F-D register selection, highest priority first.
   always_comb begin
      pc_f_d    = pc_f_q;
      pc_d_d    = pc_d_q;
      instr_d_d = instr_d_q;
      if (isbranch_taken_E) begin
         pc_f_d    = branch_pc_E;
         pc_d_d    = 32'h0000_0000;
         instr_d_d = NOP_INSTR;
      end else if (int_entry) begin
         pc_f_d    = INT_VECTOR;
         pc_d_d    = 32'h0000_0000;
         instr_d_d = NOP_INSTR;
      end else if (add_stall) begin
         pc_f_d    = pc_f_q;
         pc_d_d    = pc_d_q;
         instr_d_d = instr_d_q;
      end else begin
         // 32-bit add wraps 32'hFFFF_FFFC to 0 on its own.
         pc_f_d    = pc_f_q + 32'd4;
         pc_d_d    = pc_f_q;
         instr_d_d = imem_data;
      end
   end

   // Interrupt state machine. ACTIVE ignores interrupt (no nesting); iret
   // only matters while in the handler.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN: begin
            if (interrupt) begin
               state_d = int_entry ? S_ACTIVE : S_PEND;
            end
         end
         S_PEND: begin
            if (int_entry) begin
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (isIret_E) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_RUN;
         pc_f_q    <= RESET_PC;
         pc_d_q    <= 32'h0000_0000;
         instr_d_q <= NOP_INSTR;
      end else begin
         state_q   <= state_d;
         pc_f_q    <= pc_f_d;
         pc_d_q    <= pc_d_d;
         instr_d_q <= instr_d_d;
      end
   end

   assign imem_addr     = pc_f_q;
   assign pc_D          = pc_d_q;
   assign instruction_D = instr_d_q;
   assign int_active    = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_fetch_cycle.sv
// Purpose : self-checking bench for fetch_cycle with a behavioural model.
// Latency : checks 1 time unit after each rising edge.
// Backpressure: n/a (bench drives stall/branch/interrupt directly).
module tb_fetch_cycle;

   localparam logic [31:0] NOP   = 32'h6800_0000;
   localparam logic [31:0] IVEC  = 32'h0000_0100;
   localparam logic [31:0] SALT  = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        add_stall;
   logic        isbranch_taken_E;
   logic [31:0] branch_pc_E;
   logic        isIret_E;
   logic        interrupt;
   logic [31:0] imem_data;
   logic [31:0] imem_addr;
   logic [31:0] pc_D;
   logic [31:0] instruction_D;
   logic        int_active;

   int errors = 0;
   int checks = 0;

   // Behavioural model: fetch PC, F-D contents, a latched-request flag and
   // an in-handler flag.
   logic [31:0] m_pc, m_pcd, m_ins;
   bit          m_pend, m_hand;

   always #5 clk = ~clk;

   // Memory content is a pure function of the address.
   assign imem_data = imem_addr ^ SALT;

   fetch_cycle dut (
      .clk              (clk),
      .rst              (rst),
      .add_stall        (add_stall),
      .isbranch_taken_E (isbranch_taken_E),
      .branch_pc_E      (branch_pc_E),
      .isIret_E         (isIret_E),
      .interrupt        (interrupt),
      .imem_data        (imem_data),
      .imem_addr        (imem_addr),
      .pc_D             (pc_D),
      .instruction_D    (instruction_D),
      .int_active       (int_active)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".imem_addr"}, imem_addr, m_pc);
      chk({tag, ".pc_D"}, pc_D, m_pcd);
      chk({tag, ".instruction_D"}, instruction_D, m_ins);
      chk({tag, ".int_active"}, {31'd0, int_active}, {31'd0, m_hand});
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_pcd = 32'h0; m_ins = NOP; m_pend = 0; m_hand = 0;
   endtask

   // One clock edge of the specified behaviour, using pre-edge model state.
   task automatic model_edge(input bit br, input logic [31:0] tgt, input bit st,
                             input bit ir, input bit irq);
      bit want, was_hand;
      was_hand = m_hand;
      want     = !m_hand && (m_pend || irq);
      if (br) begin
         m_pc = tgt; m_pcd = 0; m_ins = NOP;
         if (want) m_pend = 1;
      end else if (want && !st) begin
         m_pc = IVEC; m_pcd = 0; m_ins = NOP;
         m_pend = 0; m_hand = 1;
      end else if (st) begin
         if (want) m_pend = 1;
      end else begin
         m_pcd = m_pc; m_ins = m_pc ^ SALT; m_pc = m_pc + 32'd4;
      end
      if (was_hand && ir) m_hand = 0;
   endtask

   task automatic step(input bit br, input logic [31:0] tgt, input bit st,
                       input bit ir, input bit irq, input string tag);
      isbranch_taken_E = br; branch_pc_E = tgt; add_stall = st;
      isIret_E = ir; interrupt = irq;
      @(posedge clk);
      model_edge(br, tgt, st, ir, irq);
      #1;
      chk_all(tag);
   endtask

   task automatic idle(input string tag);
      step(0, 32'h0, 0, 0, 0, tag);
   endtask

   initial begin
      rst = 1'b0; add_stall = 0; isbranch_taken_E = 0; branch_pc_E = 0;
      isIret_E = 0; interrupt = 0;
      model_reset();
      #12;
      chk_all("reset");
      rst = 1'b1;

      // Three free-running fetches from RESET_PC.
      idle("seq0");
      chk("seq0_pcd", pc_D, 32'h0);
      idle("seq1");
      chk("seq1_pcd", pc_D, 32'h4);
      idle("seq2");
      chk("seq2_pcd", pc_D, 32'h8);
      chk("seq2_ins", instruction_D, 32'h8 ^ SALT);
      chk("seq2_addr", imem_addr, 32'd12);

      // Stall at pc 16 for two edges, then resume.
      idle("to16");
      step(0, 32'h0, 1, 0, 0, "stall0");
      step(0, 32'h0, 1, 0, 0, "stall1");
      chk("stall_pc", imem_addr, 32'd16);
      chk("stall_pcd", pc_D, 32'd12);
      idle("resume");
      chk("resume_pc", imem_addr, 32'd20);

      // Branch overrides stall at pc 24.
      idle("to24");
      step(1, 32'h40, 1, 0, 0, "br_stall");
      chk("br_stall_pc", imem_addr, 32'h40);
      chk("br_stall_ins", instruction_D, NOP);

      // Interrupt colliding with a branch gets latched, enters next edge.
      step(1, 32'h8, 0, 0, 0, "to8");
      step(1, 32'h80, 0, 0, 1, "irq_br");
      chk("irq_br_pc", imem_addr, 32'h80);
      chk("irq_br_act", {31'd0, int_active}, 32'd0);
      idle("pend_entry");
      chk("entry_pc", imem_addr, IVEC);
      chk("entry_act", {31'd0, int_active}, 32'd1);

      // No nesting while active; iret with branch returns.
      step(0, 32'h0, 0, 0, 1, "nest0");
      step(0, 32'h0, 0, 0, 1, "nest1");
      chk("nest_pc", imem_addr, 32'h108);
      step(1, 32'h84, 0, 1, 0, "iret");
      chk("iret_pc", imem_addr, 32'h84);
      chk("iret_act", {31'd0, int_active}, 32'd0);

      // Pending request survives interrupt dropping during a stall.
      step(0, 32'h0, 1, 0, 1, "pend_stall");
      step(0, 32'h0, 1, 0, 0, "pend_hold");
      chk("pend_hold_act", {31'd0, int_active}, 32'd0);
      idle("pend_enter");
      chk("pend_enter_pc", imem_addr, IVEC);
      step(0, 32'h0, 0, 0, 1, "act0");
      step(0, 32'h0, 0, 0, 1, "act1");

      // Asynchronous reset mid-cycle while active at 0x108.
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk_all("async_rst");
      chk("async_rst_pc", imem_addr, 32'h0);
      // Inputs ignored while reset held across an edge.
      isbranch_taken_E = 1; branch_pc_E = 32'h500; interrupt = 1; add_stall = 1;
      @(posedge clk);
      #1;
      chk_all("rst_hold");
      #1;
      rst = 1'b1;
      idle("post_rst");

      // PC wrap at the top of the address space.
      step(1, 32'hFFFF_FFFC, 0, 0, 0, "to_top");
      idle("wrap");
      chk("wrap_pc", imem_addr, 32'h0);
      // iret outside the handler does nothing.
      step(0, 32'h0, 0, 1, 0, "iret_run");

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 4) == 0, $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 5) == 0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
